iopmp_error_capture_regs: RTL
=============================

# iopmp_error_capture_regs

Holding register bank directly downstream of the IOPMP error recorder: it latches the single error record the recorder selects, exposes it to software through a small word-addressed register port, and drives the IOPMP error interrupt. It also returns the valid flag to the recorder, which blocks further captures while a record is pending, and counts errors that were dropped while a record was held. Software acknowledges the error by clearing the valid bit, which re-arms capture.

## Interface
- No parameters; all field widths are fixed.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- rec_wr_en_i  in  1  recorder capture strobe; only asserted by the recorder while err_v_o=0
- rec_ttype_i  in  2  transaction type of the failing request
- rec_etype_i  in  4  error type of the failing request
- rec_addr_i  in  32  ERR_REQADDR value
- rec_addrh_i  in  32  ERR_REQADDRH value
- rec_reqid_i  in  32  ERR_REQID value
- fail_any_i  in  1  OR of iopmp_fail over all channels in this cycle
- reg_we_i  in  1  software write strobe
- reg_re_i  in  1  software read strobe
- reg_addr_i  in  5  byte address; bits [1:0] ignored
- reg_wdata_i  in  32  write data
- reg_rdata_o  out  32  read data, valid when reg_rvalid_o=1
- reg_rvalid_o  out  1  read response strobe
- err_v_o  out  1  ERR_REQINFO.v, fed back to the recorder
- irq_o  out  1  error interrupt, level

## Operation
- Register map (word offsets):
  - 0x00 ERR_CFG: bit0 l (lock), bit1 ie (interrupt enable).
  - 0x04 ERR_REQINFO: bit0 v, [2:1] ttype, [7:4] etype, [15:8] sup_cnt. All bits read-only except bit0, which is write-1-to-clear.
  - 0x08 ERR_REQADDR, 0x0C ERR_REQADDRH, 0x10 ERR_REQID: read-only.
  - Other offsets: read 0, writes ignored.
- ERR_CFG.l: once set, it is sticky until reset. While l=1, writes to ERR_CFG are ignored entirely.
- State machine, encoded by v:
  - IDLE (v=0): rec_wr_en_i=1 loads ttype, etype, addr, addrh and reqid, sets v=1, clears sup_cnt, and moves to LOGGED.
  - LOGGED (v=1): rec_wr_en_i is ignored and the record fields are frozen.
  - LOGGED: each cycle with fail_any_i=1 increments sup_cnt, saturating at 0xFF.
  - LOGGED: a write to 0x04 with wdata[0]=1 sets v=0 and moves to IDLE.
  - Record fields and sup_cnt are retained after the clear, so they remain readable, until the next capture overwrites them.
- The capture cycle itself does not increment sup_cnt.
- irq_o = registered (v & ie).
- Write to 0x04 with wdata[0]=0: no effect.
- Reset state: v=0, all fields 0, l=0, ie=0.

## Timing
- Capture: rec_wr_en_i sampled at edge N; fields and err_v_o are updated after edge N; irq_o rises after edge N+1 if ie=1.
- Clear: the write is sampled at edge N; err_v_o=0 after edge N; irq_o falls after edge N+1.
  - The recorder may capture a new error at edge N+1 at the earliest.
- ie change: irq_o follows one cycle after the ie update.
- Read: reg_re_i sampled at edge N; reg_rdata_o and reg_rvalid_o are valid for exactly the cycle after edge N.
  - The read returns register contents as of before edge N.
  - Back-to-back reads are supported, one per cycle.
  - reg_rdata_o=0 whenever reg_rvalid_o=0.
- Simultaneous reg_we_i and reg_re_i: both are performed; the read returns the pre-write value.
- Simultaneous clear write and fail_any_i in LOGGED: the clear wins and sup_cnt is not incremented.
- rec_wr_en_i while v=1, which is an illegal recorder behaviour: ignored; an assertion flags it.
- Reset asserted mid-operation: all state returns to reset values asynchronously; a pending read response is dropped.
- Reset values of outputs: reg_rdata_o=0, reg_rvalid_o=0, err_v_o=0, irq_o=0.

## Test plan
- Capture: set ie=1, then drive rec_wr_en_i with ttype=2, etype=5, addr=0x8000_1000, addrh=0x1, reqid=0x3.
  - err_v_o=1 on the next cycle; irq_o=1 one cycle later.
  - Read of 0x04 returns 0x0000_0055; reads of 0x08, 0x0C and 0x10 return the driven values.
- Suppression: in LOGGED, hold fail_any_i=1 for 300 cycles.
  - sup_cnt reads 0xFF.
  - Clear, then capture again: sup_cnt reads 0x00.
- Clear/re-arm: write 0x1 to 0x04.
  - err_v_o=0 the next cycle and irq_o=0 the cycle after; record fields are unchanged.
  - A new rec_wr_en_i the following cycle captures the new values.
- Clear/fail collision: issue the clear write in the same cycle as fail_any_i=1 with sup_cnt=7.
  - v=0 and sup_cnt stays 7.
- Lock: write 0x3 to 0x00, then write 0x0 to 0x00.
  - A read of 0x00 returns 0x3 and irq gating stays enabled.
- Reset mid-operation: assert rst_i asynchronously while in LOGGED with a read in flight.
  - All outputs go to 0 immediately; no reg_rvalid_o pulse occurs after reset is released.

Source files
------------

// File: rtl/iopmp_error_capture_regs.sv
// IOPMP error capture register bank: holds one error record, exposes it through a
// word-addressed register port, counts suppressed errors and drives the error interrupt.
module iopmp_error_capture_regs (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rec_wr_en_i,
    input  logic [1:0]  rec_ttype_i,
    input  logic [3:0]  rec_etype_i,
    input  logic [31:0] rec_addr_i,
    input  logic [31:0] rec_addrh_i,
    input  logic [31:0] rec_reqid_i,
    input  logic        fail_any_i,
    input  logic        reg_we_i,
    input  logic        reg_re_i,
    input  logic [4:0]  reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    output logic [31:0] reg_rdata_o,
    output logic        reg_rvalid_o,
    output logic        err_v_o,
    output logic        irq_o
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TTYPE_W = 2;
    localparam int unsigned ETYPE_W = 4;
    localparam int unsigned SUP_W   = 8;
    localparam int unsigned WORD_W  = 3;

    localparam logic [WORD_W-1:0] OFF_CFG   = WORD_W'(0);
    localparam logic [WORD_W-1:0] OFF_INFO  = WORD_W'(1);
    localparam logic [WORD_W-1:0] OFF_ADDR  = WORD_W'(2);
    localparam logic [WORD_W-1:0] OFF_ADDRH = WORD_W'(3);
    localparam logic [WORD_W-1:0] OFF_REQID = WORD_W'(4);
    localparam logic [SUP_W-1:0]  SUP_MAX   = {SUP_W{1'b1}};

    typedef enum logic {
        IDLE   = 1'b0,
        LOGGED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                cfg_l_q, cfg_l_d;
    logic                cfg_ie_q, cfg_ie_d;
    logic [TTYPE_W-1:0]  ttype_q, ttype_d;
    logic [ETYPE_W-1:0]  etype_q, etype_d;
    logic [SUP_W-1:0]    sup_cnt_q, sup_cnt_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   addrh_q, addrh_d;
    logic [DATA_W-1:0]   reqid_q, reqid_d;
    logic                irq_q, irq_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;

    logic [WORD_W-1:0]   word;
    logic                v;
    logic                clr_hit;
    logic                cfg_hit;
    logic [DATA_W-1:0]   rd_mux;
    logic                unused_bits;

    assign word    = reg_addr_i[4:2];
    assign v       = (state_q == LOGGED);
    assign clr_hit = reg_we_i && (word == OFF_INFO) && reg_wdata_i[0];
    assign cfg_hit = reg_we_i && (word == OFF_CFG) && !cfg_l_q;

    // Byte-lane bits of the address and unused write-data bits carry no meaning here.
    assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i[DATA_W-1:2]};

    // Read mux over the current (pre-edge) register contents.
    always_comb begin
        rd_mux = '0;
        case (word)
            OFF_CFG:   rd_mux = {{(DATA_W-2){1'b0}}, cfg_ie_q, cfg_l_q};
            OFF_INFO:  rd_mux = {{(DATA_W-16){1'b0}}, sup_cnt_q, etype_q, 1'b0, ttype_q, v};
            OFF_ADDR:  rd_mux = addr_q;
            OFF_ADDRH: rd_mux = addrh_q;
            OFF_REQID: rd_mux = reqid_q;
            default:   rd_mux = '0;
        endcase
    end

    // Next-state and next-register values.
    always_comb begin
        state_d   = state_q;
        cfg_l_d   = cfg_l_q;
        cfg_ie_d  = cfg_ie_q;
        ttype_d   = ttype_q;
        etype_d   = etype_q;
        sup_cnt_d = sup_cnt_q;
        addr_d    = addr_q;
        addrh_d   = addrh_q;
        reqid_d   = reqid_q;
        irq_d     = v && cfg_ie_q;
        rvalid_d  = reg_re_i;
        rdata_d   = reg_re_i ? rd_mux : '0;

        case (state_q)
            IDLE: begin
                if (rec_wr_en_i) begin
                    state_d   = LOGGED;
                    ttype_d   = rec_ttype_i;
                    etype_d   = rec_etype_i;
                    addr_d    = rec_addr_i;
                    addrh_d   = rec_addrh_i;
                    reqid_d   = rec_reqid_i;
                    sup_cnt_d = '0;
                end
            end
            LOGGED: begin
                // A clear in the same cycle as a fail wins; the fail is not counted.
                if (clr_hit) begin
                    state_d = IDLE;
                end else if (fail_any_i && (sup_cnt_q != SUP_MAX)) begin
                    sup_cnt_d = sup_cnt_q + SUP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (cfg_hit) begin
            cfg_l_d  = reg_wdata_i[0];
            cfg_ie_d = reg_wdata_i[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cfg_l_q   <= 1'b0;
            cfg_ie_q  <= 1'b0;
            ttype_q   <= '0;
            etype_q   <= '0;
            sup_cnt_q <= '0;
            addr_q    <= '0;
            addrh_q   <= '0;
            reqid_q   <= '0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_l_q   <= cfg_l_d;
            cfg_ie_q  <= cfg_ie_d;
            ttype_q   <= ttype_d;
            etype_q   <= etype_d;
            sup_cnt_q <= sup_cnt_d;
            addr_q    <= addr_d;
            addrh_q   <= addrh_d;
            reqid_q   <= reqid_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign err_v_o      = v;
    assign irq_o        = irq_q;
    assign reg_rdata_o  = rdata_q;
    assign reg_rvalid_o = rvalid_q;

    // The recorder must never strobe a capture while a record is pending.
    a_no_capture_while_logged : assert property (
        @(posedge clk_i) disable iff (rst_i) !(rec_wr_en_i && v)
    );

endmodule
